// File: rtl/imem_load_arbiter_pkg.sv
// Shared types and defaults for the instruction-memory load arbiter.
package imem_load_arbiter_pkg;

  localparam int ADDR_W_DEFAULT    = 8;
  localparam int FLUSH_CYC_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } state_e;

endpackage

// File: rtl/flush_timer.sv
// Terminal-count down-counter that holds the pipeline in reset for FLUSH_CYC cycles.
module flush_timer #(
  parameter int FLUSH_CYC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  output logic tc_o
);

  localparam int CNT_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Loaded with FLUSH_CYC-1 so the terminal count lands on the last flush cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = CNT_W'(FLUSH_CYC - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/imem_load_arbiter.sv
// Arbitrates the instruction-memory port between a program loader and the fetch stage,
// holding the pipeline in reset while a program is streamed in.
module imem_load_arbiter
  import imem_load_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int FLUSH_CYC = FLUSH_CYC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [31:0]       PCF,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              cpu_stall,
  output logic              load_done,
  output logic [ADDR_W-2:0] word_count,
  output logic              err_overflow,
  output logic              pc_fault
);

  localparam logic [ADDR_W-1:0] WPTR_MAX  = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);
  localparam logic [ADDR_W-2:0] CNT_ONE   = (ADDR_W-1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-2:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              hs;
  logic              at_end;
  logic              flush_start;
  logic              flush_tc;

  flush_timer #(.FLUSH_CYC(FLUSH_CYC)) u_flush_timer (
    .clk     (clk),
    .reset   (reset),
    .start_i (flush_start),
    .tc_o    (flush_tc)
  );

  assign ld_ready = ~reset & (state_q == LOAD) & ~err_q;
  assign hs       = ld_valid & ld_ready;
  assign at_end   = (wptr_q == WPTR_MAX);

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, RUN: begin
        if (ld_start) begin
          state_d = LOAD;
          wptr_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (hs) begin
          cnt_d = cnt_q + CNT_ONE;
          // The top word ends the load either way; the pointer never wraps.
          if (ld_last || at_end) begin
            state_d = FLUSH;
            err_d   = at_end & ~ld_last;
          end else begin
            wptr_d = wptr_q + WORD_STEP;
          end
        end
      end
      FLUSH: begin
        if (flush_tc) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign flush_start = (state_q == LOAD) && (state_d == FLUSH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    mem_addr = '0;
    unique case (state_q)
      LOAD:    mem_addr = wptr_q;
      RUN:     mem_addr = {PCF[ADDR_W-1:2], 2'b00};
      default: mem_addr = '0;
    endcase
  end

  assign mem_we       = hs;
  assign mem_wdata    = hs ? ld_data : '0;
  assign cpu_rst      = reset | (state_q != RUN);
  assign cpu_stall    = cpu_rst;
  assign load_done    = ~reset & done_q;
  assign word_count   = cnt_q;
  assign err_overflow = err_q;
  assign pc_fault     = (state_q == RUN) &
                        ((PCF[1:0] != 2'b00) | (PCF[31:ADDR_W] != '0));

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter: per-cycle check against a transaction-level model
// plus literal expectations for each scenario.
module tb_imem_load_arbiter;

  localparam int AW    = 8;
  localparam int FC    = 2;
  localparam int SLOTS = (1 << AW) / 4;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_FLUSH = 2;
  localparam int M_RUN   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_start;
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic [31:0]   PCF;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst;
  logic          cpu_stall;
  logic          load_done;
  logic [AW-2:0] word_count;
  logic          err_overflow;
  logic          pc_fault;

  imem_load_arbiter #(.ADDR_W(AW), .FLUSH_CYC(FC)) dut (
    .clk          (clk),
    .reset        (reset),
    .ld_start     (ld_start),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .PCF          (PCF),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_rst      (cpu_rst),
    .cpu_stall    (cpu_stall),
    .load_done    (load_done),
    .word_count   (word_count),
    .err_overflow (err_overflow),
    .pc_fault     (pc_fault)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what phase the controller is in, how many words were taken, sticky error.
  int m_mode       = M_IDLE;
  int m_count      = 0;
  int m_err        = 0;
  int m_flush_left = 0;
  int m_done       = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_cnt = 0;

  always @(negedge clk) begin : compare
    logic        exp_ready;
    logic        exp_hs;
    logic [31:0] exp_addr;
    logic        exp_fault;
    int          last_slot;

    exp_ready = !reset && (m_mode == M_LOAD);
    exp_hs    = exp_ready && ld_valid;
    if (m_mode == M_LOAD)     exp_addr = 32'(4 * m_count);
    else if (m_mode == M_RUN) exp_addr = PCF & 32'h0000_00FC;
    else                      exp_addr = 32'h0;
    exp_fault = (m_mode == M_RUN) && ((PCF % 4) != 0 || PCF >= 32'd256);

    check("cyc_ld_ready",   32'(ld_ready),     32'(exp_ready));
    check("cyc_mem_we",     32'(mem_we),       32'(exp_hs));
    check("cyc_mem_addr",   32'(mem_addr),     exp_addr);
    check("cyc_cpu_rst",    32'(cpu_rst),      32'(reset || m_mode != M_RUN));
    check("cyc_cpu_stall",  32'(cpu_stall),    32'(reset || m_mode != M_RUN));
    check("cyc_load_done",  32'(load_done),    32'(!reset && m_done != 0));
    check("cyc_word_count", 32'(word_count),   32'(m_count));
    check("cyc_err",        32'(err_overflow), 32'(m_err));
    check("cyc_pc_fault",   32'(pc_fault),     32'(exp_fault));
    if (exp_hs) check("cyc_mem_wdata", mem_wdata, ld_data);

    if (mem_we) begin
      wr_addr_q.push_back(32'(mem_addr));
      wr_data_q.push_back(mem_wdata);
    end
    if (load_done) done_cnt++;

    if (reset) begin
      m_mode  = M_IDLE;
      m_count = 0;
      m_err   = 0;
      m_done  = 0;
    end else begin
      m_done = 0;
      case (m_mode)
        M_IDLE, M_RUN: begin
          if (ld_start) begin
            m_mode  = M_LOAD;
            m_count = 0;
            m_err   = 0;
          end
        end
        M_LOAD: begin
          if (exp_hs) begin
            last_slot = (m_count == SLOTS - 1) ? 1 : 0;
            m_count++;
            if (ld_last || last_slot != 0) begin
              m_mode       = M_FLUSH;
              m_flush_left = FC;
              m_err        = ld_last ? 0 : 1;
            end
          end
        end
        default: begin
          m_flush_left--;
          if (m_flush_left == 0) begin
            m_mode = M_RUN;
            m_done = 1;
          end
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic wait_run();
    int k = 0;
    while (cpu_rst === 1'b1 && k < 30) begin
      tick();
      k++;
    end
    check("reach_run", 32'(cpu_rst), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset    = 1'b1;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = 32'h0;
    PCF      = 32'h0;
    repeat (3) tick();
    check("rst_cpu_rst",    32'(cpu_rst),      32'h1);
    check("rst_cpu_stall",  32'(cpu_stall),    32'h1);
    check("rst_ld_ready",   32'(ld_ready),     32'h0);
    check("rst_mem_we",     32'(mem_we),       32'h0);
    check("rst_load_done",  32'(load_done),    32'h0);
    check("rst_word_count", 32'(word_count),   32'h0);
    check("rst_err",        32'(err_overflow), 32'h0);
    reset = 1'b0;
    tick();

    // Basic three-word load
    done_cnt = 0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    clear_log();
    send_word(32'h0000_0093, 1'b0);
    send_word(32'h0010_0113, 1'b0);
    send_word(32'h00F0_0193, 1'b1);
    k = 0;
    while (cpu_rst === 1'b1 && k < 10) begin
      tick();
      k++;
    end
    check("basic_flush_len", 32'(k), 32'd2);
    repeat (3) tick();
    check("basic_nwrites", 32'(wr_addr_q.size()), 32'd3);
    check("basic_addr0",   wr_addr_q[0], 32'd0);
    check("basic_addr1",   wr_addr_q[1], 32'd4);
    check("basic_addr2",   wr_addr_q[2], 32'd8);
    check("basic_data0",   wr_data_q[0], 32'h0000_0093);
    check("basic_data1",   wr_data_q[1], 32'h0010_0113);
    check("basic_data2",   wr_data_q[2], 32'h00F0_0193);
    check("basic_wcount",  32'(word_count), 32'd3);
    check("model_wcount",  32'(m_count),    32'd3);
    check("basic_done_pulses", 32'(done_cnt), 32'd1);

    // Fetch mux in RUN
    PCF = 32'd20;
    #1;
    check("fetch20_addr",  32'(mem_addr), 32'd20);
    check("fetch20_we",    32'(mem_we),   32'h0);
    check("fetch20_fault", 32'(pc_fault), 32'h0);
    PCF = 32'd22;
    #1;
    check("fetch22_fault", 32'(pc_fault), 32'h1);
    check("fetch22_addr",  32'(mem_addr), 32'd20);
    PCF = 32'd256;
    #1;
    check("fetch256_fault", 32'(pc_fault), 32'h1);
    check("fetch256_addr",  32'(mem_addr), 32'd0);
    tick();
    PCF = 32'h0;

    // Reload from RUN with a word offered on the same cycle, then gapped stream
    clear_log();
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 32'hDEAD_0000;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    check("reload_cpu_rst", 32'(cpu_rst),    32'h1);
    check("reload_wcount",  32'(word_count), 32'h0);
    check("reload_nowrite", 32'(wr_addr_q.size()), 32'd0);
    for (int i = 0; i < 5; i++) begin
      ld_valid = (i % 2 == 0);
      ld_data  = 32'hA000_0000 + 32'(i);
      ld_last  = (i == 4);
      ld_start = (i == 1);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_start = 1'b0;
    check("gap_nwrites", 32'(wr_addr_q.size()), 32'd3);
    check("gap_addr1",   wr_addr_q[1], 32'd4);
    check("gap_addr2",   wr_addr_q[2], 32'd8);
    check("gap_data1",   wr_data_q[1], 32'hA000_0002);
    check("gap_data2",   wr_data_q[2], 32'hA000_0004);
    wait_run();
    check("gap_wcount",  32'(word_count), 32'd3);

    // Overflow: 65 words without ld_last
    done_cnt = 0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    clear_log();
    for (int i = 0; i < 65; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'(i);
      ld_last  = 1'b0;
      tick();
    end
    ld_valid = 1'b0;
    check("ovf_nwrites",   32'(wr_addr_q.size()), 32'd64);
    check("ovf_last_addr", wr_addr_q[63], 32'd252);
    check("ovf_last_data", wr_data_q[63], 32'd63);
    check("ovf_err",       32'(err_overflow), 32'h1);
    check("ovf_wcount",    32'(word_count),   32'd64);
    check("model_ovf_err", 32'(m_err),        32'h1);
    wait_run();
    check("ovf_err_sticky", 32'(err_overflow), 32'h1);
    check("ovf_done",       32'(done_cnt),     32'd1);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("ovf_reload_err",    32'(err_overflow), 32'h0);
    check("ovf_reload_wcount", 32'(word_count),   32'h0);
    check("ovf_reload_rst",    32'(cpu_rst),      32'h1);

    // Mid-load reset
    clear_log();
    send_word(32'h0000_0011, 1'b0);
    send_word(32'h0000_0022, 1'b0);
    check("midrst_pre_wcount", 32'(word_count), 32'd2);
    reset = 1'b1;
    tick();
    check("midrst_ready",  32'(ld_ready),   32'h0);
    check("midrst_wcount", 32'(word_count), 32'h0);
    reset = 1'b0;
    #1;
    check("midrst_idle_ready", 32'(ld_ready), 32'h0);
    check("midrst_cpu_rst",    32'(cpu_rst),  32'h1);
    tick();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    clear_log();
    send_word(32'h0000_0033, 1'b1);
    check("midrst_nwrites", 32'(wr_addr_q.size()), 32'd1);
    check("midrst_addr0",   wr_addr_q[0], 32'd0);
    check("midrst_data0",   wr_data_q[0], 32'h0000_0033);
    wait_run();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_load_arbiter.md
IMEM_LOAD_ARBITER -- requirements
Module: imem_load_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the instruction-memory byte-address width (256-byte span).
REQ-002 The block SHALL have parameter FLUSH_CYC, default 2, meaning the number of cycles the pipeline stays in reset after a load completes.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port ld_start, input, 1 bit: request a program load.
REQ-006 The block SHALL have ports ld_valid (input, 1 bit), ld_data (input, 32 bits) and ld_last (input, 1 bit): loader word stream.
REQ-007 The block SHALL have port ld_ready, output, 1 bit: loader word accepted this cycle when ld_valid is also high.
REQ-008 The block SHALL have port PCF, input, 32 bits: fetch byte address from the pipeline.
REQ-009 The block SHALL have ports mem_we (output, 1 bit), mem_addr (output, ADDR_W bits) and mem_wdata (output, 32 bits): instruction-memory access port.
REQ-010 The block SHALL have ports cpu_rst (output, 1 bit) and cpu_stall (output, 1 bit): pipeline hold controls.
REQ-011 The block SHALL have ports load_done (output, 1 bit), word_count (output, ADDR_W-1 bits), err_overflow (output, 1 bit) and pc_fault (output, 1 bit): status outputs.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, LOAD, FLUSH, RUN.
REQ-013 IDLE SHALL go to LOAD when ld_start=1; otherwise it SHALL stay in IDLE.
REQ-014 LOAD SHALL go to FLUSH on a handshake with ld_last=1, or on overflow.
REQ-015 FLUSH SHALL go to RUN after FLUSH_CYC cycles.
REQ-016 RUN SHALL go to LOAD when ld_start=1.
REQ-017 ld_ready SHALL be 1 only in LOAD, and only while err_overflow=0.
REQ-018 A handshake SHALL be ld_valid & ld_ready, and only a handshake SHALL cause a write.
REQ-019 On a handshake, in the same cycle: mem_we=1, mem_addr=wptr, mem_wdata=ld_data; the write latency SHALL be 0.
REQ-020 wptr SHALL start at 0 on entry to LOAD and advance by 4 per handshake, giving word addresses 0, 4, 8, …, 2^ADDR_W-4.
REQ-021 word_count SHALL equal the number of handshakes since entry to LOAD, and SHALL hold its value after LOAD ends.
REQ-022 Overflow: a handshake that writes address 2^ADDR_W-4 without ld_last SHALL set err_overflow, go to FLUSH, and SHALL NOT wrap wptr.
REQ-023 err_overflow SHALL be sticky until the next entry to LOAD or reset.
REQ-024 cpu_rst SHALL be 1 in IDLE, LOAD and FLUSH, and 0 in RUN.
REQ-025 cpu_stall SHALL equal cpu_rst.
REQ-026 In RUN: mem_we=0 and mem_addr={PCF[ADDR_W-1:2],2'b00}.
REQ-027 pc_fault SHALL be combinational: 1 in RUN when PCF[1:0]≠0 or PCF[31:ADDR_W]≠0, otherwise 0.
REQ-028 In IDLE and FLUSH: mem_we=0 and mem_addr=0.
REQ-029 load_done SHALL be a 1-cycle pulse in the first RUN cycle after FLUSH.
REQ-030 If ld_start=1 in LOAD, it SHALL be ignored.
REQ-031 If ld_start and ld_valid are both 1 in IDLE or RUN, the transition SHALL be taken and no word accepted that cycle.
REQ-032 In LOAD with ld_valid=0, the block SHALL hold state, with no write and no wptr change.

Reset
REQ-033 While reset=1 at a clk edge, the block SHALL set: state=IDLE, wptr=0, word_count=0, err_overflow=0, FLUSH counter=0.
REQ-034 While in reset, the outputs SHALL be: cpu_rst=1, cpu_stall=1, ld_ready=0, mem_we=0, load_done=0.
REQ-035 A reset during LOAD SHALL abort the load; words already written SHALL remain in memory.

Structure
REQ-036 The state encoding localparams (IDLE=2'd0, LOAD=2'd1, FLUSH=2'd2, RUN=2'd3) SHALL live in a shared package/include with the ADDR_W default.
REQ-037 The FLUSH down-counter MAY be a sub-module named flush_timer.
REQ-038 All other logic SHALL be flat.
REQ-039 Instruction memory SHALL stay external; the existing fetch-only memory gains a write port driven by mem_we, mem_addr and mem_wdata.

Verification
REQ-040 Basic load: reset, ld_start, 3 words (0x00000093, 0x00100113, 0x00F00193; last on the 3rd) → writes at addresses 0, 4, 8; word_count=3; cpu_rst falls 2 cycles after the last word; load_done pulses once.
REQ-041 Backpressure gaps: ld_valid toggling 1-0-1-0 → writes only on valid cycles; wptr contiguous.
REQ-042 Overflow: 65 words, no ld_last → 64 writes up to address 252; err_overflow=1; 65th word not accepted; RUN reached.
REQ-043 Fetch mux: RUN, PCF=20 → mem_addr=20, mem_we=0; PCF=22 → pc_fault=1; PCF=256 → pc_fault=1.
REQ-044 Reload: ld_start in RUN → cpu_rst=1 next cycle; word_count restarts at 0; err_overflow cleared.
REQ-045 Mid-load reset: reset after 2 words → IDLE, ld_ready=0, word_count=0; next load starts at address 0.
